// File: rtl/ro_puf_pkg.sv
// ro_puf_pkg: shared state encoding, default sizing and challenge check for the RO PUF controller
package ro_puf_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_COUNT,
        ST_DRAIN,
        ST_CMP,
        ST_RESP
    } state_e;

    localparam int N_RO_DEF   = 16;
    localparam int SEL_W_DEF  = 4;
    localparam int CNT_W_DEF  = 16;
    localparam int WINDOW_DEF = 1024;
    localparam int SETTLE_DEF = 8;
    localparam int DRAIN_DEF  = 3;

    // a usable challenge names two different oscillators that both exist in the bank
    function automatic logic chal_valid(input logic [31:0] a, input logic [31:0] b, input int n);
        return (a != b) && (a < 32'(n)) && (b < 32'(n));
    endfunction

endpackage

// File: rtl/ro_edge_counter.sv
// ro_edge_counter: synchronizes one oscillator, detects rising edges and counts them with saturation
module ro_edge_counter
    import ro_puf_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             cnt_en,
    input  logic             ro_in,
    output logic [CNT_W-1:0] count
);

    logic [2:0]       sync_q, sync_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             rise;

    assign rise  = sync_q[1] & ~sync_q[2];
    assign count = count_q;

    // two synchronizer stages plus one history stage for edge detection; saturating count
    always_comb begin
        sync_d  = {sync_q[1:0], ro_in};
        count_d = clr ? '0 : (cnt_en && rise && !(&count_q)) ? count_q + 1'b1 : count_q;
    end

    // state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= '0;
            count_q <= '0;
        end else begin
            sync_q  <= sync_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/ro_puf_ctrl.sv
// ro_puf_ctrl: challenge/response sequencer that races two ring oscillators over a fixed window
module ro_puf_ctrl
    import ro_puf_pkg::*;
#(
    parameter int N_RO   = N_RO_DEF,
    parameter int SEL_W  = SEL_W_DEF,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int WINDOW = WINDOW_DEF,
    parameter int SETTLE = SETTLE_DEF,
    parameter int DRAIN  = DRAIN_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [SEL_W-1:0] chal_a,
    input  logic [SEL_W-1:0] chal_b,
    input  logic             abort,
    output logic             busy,
    output logic [N_RO-1:0]  ro_en,
    input  logic [N_RO-1:0]  ro_out,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic             response,
    output logic             tie,
    output logic             err,
    output logic [CNT_W-1:0] cnt_a,
    output logic [CNT_W-1:0] cnt_b
);

    localparam int TW = $clog2(SETTLE + WINDOW + DRAIN + 1);

    state_e           state_q, state_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [SEL_W-1:0] sel_a_q, sel_a_d, sel_b_q, sel_b_d;
    logic [N_RO-1:0]  ro_en_q, ro_en_d;
    logic             busy_q, busy_d, resp_valid_q, resp_valid_d;
    logic             response_q, response_d, tie_q, tie_d, err_q, err_d;
    logic [CNT_W-1:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d, raw_a, raw_b;
    logic             clr, cnt_en, chal_ok;

    assign chal_ok    = chal_valid(32'(chal_a), 32'(chal_b), N_RO);
    assign cnt_en     = (state_q == ST_COUNT) || (state_q == ST_DRAIN);
    assign busy       = busy_q;
    assign ro_en      = ro_en_q;
    assign resp_valid = resp_valid_q;
    assign response   = response_q;
    assign tie        = tie_q;
    assign err        = err_q;
    assign cnt_a      = cnt_a_q;
    assign cnt_b      = cnt_b_q;

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_a (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .cnt_en(cnt_en),
        .ro_in (ro_out[sel_a_q]),
        .count (raw_a)
    );

    ro_edge_counter #(.CNT_W(CNT_W)) u_cnt_b (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .cnt_en(cnt_en),
        .ro_in (ro_out[sel_b_q]),
        .count (raw_b)
    );

    // sequencer next state; abort overrides everything outside IDLE, outputs are derived from the next state
    always_comb begin
        state_d    = state_q;
        tmr_d      = tmr_q;
        sel_a_d    = sel_a_q;
        sel_b_d    = sel_b_q;
        ro_en_d    = ro_en_q;
        response_d = response_q;
        tie_d      = tie_q;
        err_d      = err_q;
        cnt_a_d    = cnt_a_q;
        cnt_b_d    = cnt_b_q;
        clr        = 1'b0;
        if (abort && state_q != ST_IDLE) begin
            state_d = ST_IDLE;
            ro_en_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: if (start && !abort) begin
                    sel_a_d    = chal_a;
                    sel_b_d    = chal_b;
                    clr        = 1'b1;
                    response_d = 1'b0;
                    tie_d      = 1'b0;
                    cnt_a_d    = '0;
                    cnt_b_d    = '0;
                    err_d      = !chal_ok;
                    state_d    = chal_ok ? ST_SETTLE : ST_RESP;
                    ro_en_d    = chal_ok ? (N_RO'(1) << chal_a) | (N_RO'(1) << chal_b) : '0;
                    tmr_d      = TW'(SETTLE - 1);
                end
                ST_SETTLE: begin
                    state_d = (tmr_q == '0) ? ST_COUNT : ST_SETTLE;
                    tmr_d   = (tmr_q == '0) ? TW'(WINDOW - 1) : tmr_q - 1'b1;
                end
                ST_COUNT: if (tmr_q == '0) begin
                    ro_en_d = '0;
                    state_d = (DRAIN == 0) ? ST_CMP : ST_DRAIN;
                    tmr_d   = TW'(DRAIN - 1);
                end else begin
                    tmr_d = tmr_q - 1'b1;
                end
                ST_DRAIN: begin
                    state_d = (tmr_q == '0) ? ST_CMP : ST_DRAIN;
                    tmr_d   = tmr_q - 1'b1;
                end
                ST_CMP: begin
                    response_d = raw_a > raw_b;
                    tie_d      = raw_a == raw_b;
                    err_d      = 1'b0;
                    cnt_a_d    = raw_a;
                    cnt_b_d    = raw_b;
                    state_d    = ST_RESP;
                end
                ST_RESP: state_d = resp_ready ? ST_IDLE : ST_RESP;
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d       = state_d != ST_IDLE;
        resp_valid_d = state_d == ST_RESP;
    end

    // state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            sel_a_q      <= '0;
            sel_b_q      <= '0;
            ro_en_q      <= '0;
            busy_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            response_q   <= 1'b0;
            tie_q        <= 1'b0;
            err_q        <= 1'b0;
            cnt_a_q      <= '0;
            cnt_b_q      <= '0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            sel_a_q      <= sel_a_d;
            sel_b_q      <= sel_b_d;
            ro_en_q      <= ro_en_d;
            busy_q       <= busy_d;
            resp_valid_q <= resp_valid_d;
            response_q   <= response_d;
            tie_q        <= tie_d;
            err_q        <= err_d;
            cnt_a_q      <= cnt_a_d;
            cnt_b_q      <= cnt_b_d;
        end
    end

endmodule

// File: tb/tb_ro_puf_ctrl.sv
// tb_ro_puf_ctrl: randomized challenge runs against an oscillator-bank model that counts edges over the window
module tb_ro_puf_ctrl;

    localparam int S = 8, W = 1024, D = 3;
    localparam int LAT = 1 + S + W + D + 1;

    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, resp_ready = 1'b1;
    logic [3:0]  chal_a = '0, chal_b = '0;
    logic [15:0] ro_en, ro_out = '0;
    logic        busy, resp_valid, response, tie, err;
    logic [15:0] cnt_a, cnt_b;

    logic        s_start = 1'b0, s_abort = 1'b0, s_ready = 1'b1;
    logic [3:0]  s_chal_a = 4'd1, s_chal_b = 4'd2;
    logic [15:0] s_ro_en, s_ro_out = '0;
    logic        s_busy, s_valid, s_response, s_tie, s_err;
    logic [5:0]  s_cnt_a, s_cnt_b;

    int per[16]   = '{default: 8};
    int ph_m[16]  = '{default: 0};
    int ph_s[16]  = '{default: 0};
    int rises[16] = '{default: 0};
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    ro_puf_ctrl u_dut (
        .clk(clk), .rst(rst), .start(start), .chal_a(chal_a), .chal_b(chal_b), .abort(abort),
        .busy(busy), .ro_en(ro_en), .ro_out(ro_out), .resp_valid(resp_valid), .resp_ready(resp_ready),
        .response(response), .tie(tie), .err(err), .cnt_a(cnt_a), .cnt_b(cnt_b)
    );

    ro_puf_ctrl #(.CNT_W(6)) u_sat (
        .clk(clk), .rst(rst), .start(s_start), .chal_a(s_chal_a), .chal_b(s_chal_b), .abort(s_abort),
        .busy(s_busy), .ro_en(s_ro_en), .ro_out(s_ro_out), .resp_valid(s_valid), .resp_ready(s_ready),
        .response(s_response), .tie(s_tie), .err(s_err), .cnt_a(s_cnt_a), .cnt_b(s_cnt_b)
    );

    // oscillator bank model: each enabled oscillator is low for per/2 cycles then high, stopped when disabled
    always @(posedge clk) begin
        #2;
        for (int i = 0; i < 16; i++) begin
            logic nv;
            ph_m[i] = ro_en[i] ? (ph_m[i] + 1) % per[i] : 0;
            ph_s[i] = s_ro_en[i] ? (ph_s[i] + 1) % per[i] : 0;
            nv = ro_en[i] && ph_m[i] >= per[i] / 2;
            if (nv && !ro_out[i]) rises[i]++;
            ro_out[i]   = nv;
            s_ro_out[i] = s_ro_en[i] && ph_s[i] >= per[i] / 2;
        end
    end

    task automatic chk(input string tag, input longint got, input longint lo, input longint hi);
        total++;
        if (got < lo || got > hi) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d..%0d", tag, got, lo, hi);
        end
    endtask

    // one challenge on the main DUT; expectations come from the bank model's edge tally over the window
    task automatic measure(input logic [3:0] a, input logic [3:0] b, input bit hold, input string nm);
        int lat = 1, ra0 = 0, rb0 = 0, na = 0, nb = 0;
        bit ok = (a != b);
        logic [15:0] m = (16'd1 << a) | (16'd1 << b);
        resp_ready = !hold;
        @(negedge clk);
        chal_a = a; chal_b = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while (lat < 2000) begin
            @(negedge clk);
            if (lat == S - 1) begin ra0 = rises[a]; rb0 = rises[b]; end
            if (lat == S + W + 1) begin na = rises[a] - ra0; nb = rises[b] - rb0; end
            if (lat == 2) begin chk({nm, "_ro_en_settle"}, ro_en, m, m); chk({nm, "_busy"}, busy, 1, 1); end
            if (lat == S + W) chk({nm, "_ro_en_count"}, ro_en, m, m);
            if (lat == S + W + 1) chk({nm, "_ro_en_drain"}, ro_en, 0, 0);
            if (resp_valid) break;
            @(posedge clk);
            lat++;
        end
        chk({nm, "_latency"}, lat, ok ? LAT : 1, ok ? LAT : 1);
        chk({nm, "_err"}, err, !ok, !ok);
        chk({nm, "_tie"}, tie, 0, 0);
        chk({nm, "_response"}, response, ok && na > nb, ok && na > nb);
        chk({nm, "_cnt_a"}, cnt_a, ok ? na - 1 : 0, ok ? na + 1 : 0);
        chk({nm, "_cnt_b"}, cnt_b, ok ? nb - 1 : 0, ok ? nb + 1 : 0);
        if (!ok) chk({nm, "_ro_en_inv"}, ro_en, 0, 0);
        if (hold) begin
            repeat (50) begin
                start = ~start; chal_a = 4'($urandom); chal_b = 4'($urandom);
                @(negedge clk);
                chk({nm, "_hold_valid"}, resp_valid, 1, 1);
                chk({nm, "_hold_cnt_a"}, cnt_a, ok ? na - 1 : 0, ok ? na + 1 : 0);
                chk({nm, "_hold_resp"}, response, ok && na > nb, ok && na > nb);
            end
            start = 1'b0;
            resp_ready = 1'b1;
        end
        @(negedge clk);
        chk({nm, "_valid_drop"}, resp_valid, 0, 0);
        chk({nm, "_idle"}, busy, 0, 0);
    endtask

    initial begin
        int lat;
        bit seen;
        #12;
        chk("reset_flags", {ro_en, busy, resp_valid, response, tie, err}, 0, 0);
        chk("reset_cnts", {cnt_a, cnt_b}, 0, 0);
        @(negedge clk) rst = 1'b0;

        per[3] = 10; per[7] = 14;
        measure(3, 7, 0, "base");
        measure(7, 3, 0, "swap");
        measure(5, 5, 0, "same");
        measure(15, 15, 0, "same_hi");

        for (int k = 0; k < 6; k++) begin
            logic [3:0] a = 4'($urandom_range(0, 15));
            logic [3:0] b = 4'($urandom_range(0, 15));
            int pa = $urandom_range(4, 16);
            if (a == b) b = a + 4'd1;
            per[a] = pa;
            per[b] = pa + $urandom_range(3, 8);
            if ($urandom_range(0, 1)) begin per[a] = per[b]; per[b] = pa; end
            measure(a, b, 0, "rand");
        end

        @(negedge clk);
        start = 1'b1; abort = 1'b1; chal_a = 4'd3; chal_b = 4'd7;
        @(posedge clk);
        #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy, 0, 0);
        chk("start_abort_ro_en", ro_en, 0, 0);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (S + 100) @(posedge clk);
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_ro_en", ro_en, 0, 0);
        chk("abort_busy", busy, 0, 0);
        seen = 0;
        repeat (1100) begin
            @(negedge clk);
            if (resp_valid) seen = 1;
        end
        chk("abort_no_valid", seen, 0, 0);
        measure(3, 7, 0, "post_abort");

        measure(3, 7, 1, "hold");

        @(negedge clk);
        chal_a = 4'd3; chal_b = 4'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (S + 50) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("rst_mid_flags", {ro_en, busy, resp_valid, response, tie, err}, 0, 0);
        chk("rst_mid_cnts", {cnt_a, cnt_b}, 0, 0);
        @(negedge clk) rst = 1'b0;

        per[1] = 4; per[2] = 6;
        @(negedge clk) s_start = 1'b1;
        @(posedge clk);
        #1 s_start = 1'b0;
        lat = 1;
        while (lat < 2000) begin
            @(negedge clk);
            if (s_valid) break;
            @(posedge clk);
            lat++;
        end
        chk("sat_latency", lat, LAT, LAT);
        chk("sat_cnt_a", s_cnt_a, 63, 63);
        chk("sat_cnt_b", s_cnt_b, 63, 63);
        chk("sat_tie", s_tie, 1, 1);
        chk("sat_response", s_response, 0, 0);
        chk("sat_err", s_err, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ro_puf_ctrl.md
Name: ro_puf_ctrl

Overview:
Challenge/response sequencer for a ring-oscillator PUF bank. On a challenge it enables two selected ring oscillators, counts their rising edges over a fixed window in the system clock domain, and compares the counts. It returns one response bit plus both raw counts through a valid/ready handshake. The block sits between the PUF bank (N_RO enable-gated oscillators) and the host or key-generation logic.

Parameters:
N_RO, 16, number of ring oscillators in the bank
SEL_W, 4, challenge index width; must satisfy 2**SEL_W >= N_RO
CNT_W, 16, edge counter width
WINDOW, 1024, count window length in clk cycles (>= 1)
SETTLE, 8, clk cycles between enable and start of counting (>= 1)
DRAIN, 3, clk cycles after the window closes while counting continues, to flush the synchronizer pipeline

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
start  in  1  challenge request; accepted only in IDLE
chal_a  in  SEL_W  index of oscillator A
chal_b  in  SEL_W  index of oscillator B
abort  in  1  cancel the current measurement and return to IDLE
busy  out  1  high in every state except IDLE
ro_en  out  N_RO  one-hot-pair enable to the oscillator bank
ro_out  in  N_RO  raw oscillator outputs (asynchronous to clk)
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts the response
response  out  1  1 when cnt_a > cnt_b, otherwise 0
tie  out  1  cnt_a == cnt_b
err  out  1  invalid challenge (chal_a == chal_b, or either index >= N_RO)
cnt_a  out  CNT_W  edge count for oscillator A
cnt_b  out  CNT_W  edge count for oscillator B

Behaviour:
- Reset (async, active-high): state IDLE. ro_en, busy, resp_valid, response, tie, err, cnt_a and cnt_b are all 0. The oscillators stop on the same edge as reset asserts.
- IDLE: when start=1, latch chal_a and chal_b and clear both counters.
  - Invalid challenge: go to RESP with err=1, response=0, tie=0, counts=0. ro_en stays 0.
  - Valid challenge: set ro_en bits chal_a and chal_b, and go to SETTLE.
- SETTLE: wait SETTLE cycles with counters held at 0, then go to COUNT.
- COUNT: for exactly WINDOW cycles, each counter increments on every synchronized rising edge of its oscillator. Then clear ro_en and go to DRAIN.
- DRAIN: counting continues for DRAIN cycles so in-flight synchronized edges are captured. Then go to CMP.
- CMP: one cycle. Register response, tie and the counts; err=0. Go to RESP.
- RESP: resp_valid=1 and all outputs are held stable. When resp_valid and resp_ready are both high, go to IDLE; resp_valid drops on the next cycle. A start during RESP is ignored.
- Latency from start to resp_valid for a valid challenge: 1 + SETTLE + WINDOW + DRAIN + 1 cycles. For an invalid challenge: 1 cycle.
- Edge detection: 2-flop synchronizer per selected oscillator, then rising-edge detect on the synchronized value. Counts are accurate only when the oscillator frequency is below clk/4; the block does not check this.
- Counters saturate at 2**CNT_W-1 and never wrap. If both saturate, tie=1.
- abort (any state except IDLE): ro_en cleared combinationally-registered on the next edge, state goes to IDLE, no response is produced, and resp_valid drops. abort has priority over resp_ready.
- Simultaneous start and abort in IDLE: abort wins and start is ignored.
- Only the two selected oscillators are ever enabled; ro_en never has more than 2 bits set.

Decomposition:
- Shared package ro_puf_pkg: state enum {IDLE, SETTLE, COUNT, DRAIN, CMP, RESP}, default parameter constants, and a function that checks challenge validity.
- Sub-module ro_edge_counter, instantiated twice (A and B). It contains the synchronizer, edge detect and saturating counter, with inputs clk, rst, clr, cnt_en, ro_in and output count.
- A and B each mux their ro_in from ro_out using the latched index.

Test Plan:
- Defaults. Model oscillator 3 with period 10 clk and oscillator 7 with period 14 clk; start with chal_a=3, chal_b=7, resp_ready=1 -> resp_valid 1037 cycles after start; cnt_a 102-103; cnt_b 73-74; response=1; tie=0; err=0; ro_en=0x0088 during SETTLE through COUNT.
- Swap the same stimulus (chal_a=7, chal_b=3) -> response=0; counts swapped.
- chal_a=chal_b=5 -> resp_valid 1 cycle later; err=1; response=0; ro_en stays 0.
- Reduce CNT_W to 6 and run oscillators of period 4 and 6 with WINDOW=1024 -> cnt_a=cnt_b=63; tie=1; response=0.
- Assert abort 100 cycles into COUNT -> ro_en=0 and busy=0 on the next cycle; resp_valid never asserts; a following start runs normally.
- Hold resp_ready=0 for 50 cycles in RESP while toggling start -> outputs stable; no new measurement starts; state is IDLE 1 cycle after resp_ready=1. Also assert rst mid-COUNT -> all outputs 0 immediately.
